// File: rtl/tl_mem_responder.sv
// rtl/tl_mem_responder.sv - TileLink-UL-style memory responder: one A request at a time, optional wait, held D response
// Serves Get/PutFullData against a word-addressed memory; the D beat stays registered until d_ready.
module tl_mem_responder #(
  parameter int         DEPTH     = 1024,
  parameter int         LATENCY   = 0,
  parameter logic [2:0] SIZE_CODE = 3'b101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [54:0] a_channel,
  output logic        a_ready,
  output logic [46:0] d_channel,
  input  logic        d_ready,
  output logic [1:0]  resp_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [2:0]  r_op;
  logic [2:0]  r_param;
  logic [2:0]  r_size;
  logic [1:0]  r_source;
  logic [AW-1:0] r_addr;
  logic [31:0] r_data;
  logic [46:0] r_d;
  logic [31:0] r_mem [DEPTH];

  logic        w_a_valid;
  logic        w_live;
  logic        w_access;
  logic [2:0]  w_op;
  logic [2:0]  w_param;
  logic [2:0]  w_size;
  logic [1:0]  w_source;
  logic [AW-1:0] w_addr;
  logic [31:0] w_data;
  logic        w_err;
  logic        w_is_get;
  logic        w_is_put;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_a_valid = a_channel[1];
  assign w_unused  = a_channel[0];

  // With LATENCY==0 the access happens on the acceptance edge, so use the live A fields then.
  assign w_live   = (r_state == S_IDLE);
  assign w_op     = w_live ? a_channel[54:52]      : r_op;
  assign w_param  = w_live ? a_channel[51:49]      : r_param;
  assign w_size   = w_live ? a_channel[48:46]      : r_size;
  assign w_source = w_live ? a_channel[45:44]      : r_source;
  assign w_addr   = w_live ? a_channel[34 +: AW]   : r_addr;
  assign w_data   = w_live ? a_channel[33:2]       : r_data;

  assign w_err    = !((w_op == 3'b000) || (w_op == 3'b100)) || (w_param != 3'b000) ||
                    (w_size != SIZE_CODE);
  assign w_is_get = (w_op == 3'b100);
  assign w_is_put = (w_op == 3'b000) && !w_err;
  assign w_rdata  = (w_is_get && !w_err) ? r_mem[w_addr] : 32'h0;

  always_comb begin
    w_next   = r_state;
    w_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_a_valid) begin
          if (LATENCY == 0) begin
            w_next   = S_RESP;
            w_access = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next   = S_RESP;
          w_access = 1'b1;
        end
      end
      S_RESP: begin
        if (d_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_op     <= 3'd0;
      r_param  <= 3'd0;
      r_size   <= 3'd0;
      r_source <= 2'd0;
      r_addr   <= '0;
      r_data   <= 32'd0;
      r_d      <= 47'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_a_valid) begin
        r_op     <= a_channel[54:52];
        r_param  <= a_channel[51:49];
        r_size   <= a_channel[48:46];
        r_source <= a_channel[45:44];
        r_addr   <= a_channel[34 +: AW];
        r_data   <= a_channel[33:2];
        r_cnt    <= 4'(LATENCY);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_d <= {(w_is_get ? 3'b001 : 3'b000), 2'b00, 2'b00, w_size, w_source, w_err,
                w_rdata, 1'b1, 1'b0};
      end else if (r_state == S_RESP && d_ready) begin
        r_d[1] <= 1'b0;
      end
    end
  end

  // Memory is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_access && w_is_put) r_mem[w_addr] <= w_data;
  end

  assign a_ready    = (r_state == S_IDLE);
  assign d_channel  = r_d;
  assign resp_state = r_state;

endmodule

// File: tb/tb_tl_mem_responder.sv
// tb/tb_tl_mem_responder.sv - self-checking bench for tl_mem_responder (LATENCY 0 and 3 instances)
module tb_tl_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [54:0] a_ch  [2];
  logic [46:0] d_ch  [2];
  logic        d_rdy [2];
  logic        a_rdy [2];
  logic        rstn  [2];
  logic [1:0]  st    [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl [2][1024];

  tl_mem_responder #(.LATENCY(0)) u0 (
    .clk(clk), .rst_n(rstn[0]), .a_channel(a_ch[0]), .a_ready(a_rdy[0]),
    .d_channel(d_ch[0]), .d_ready(d_rdy[0]), .resp_state(st[0]));

  tl_mem_responder #(.LATENCY(3)) u3 (
    .clk(clk), .rst_n(rstn[1]), .a_channel(a_ch[1]), .a_ready(a_rdy[1]),
    .d_channel(d_ch[1]), .d_ready(d_rdy[1]), .resp_state(st[1]));

  // Reference: what the responder should return, and the memory it should hold afterwards.
  task automatic model(input int k, input logic [2:0] op, input logic [2:0] prm,
                       input logic [2:0] sz, input logic [1:0] src, input logic [9:0] addr,
                       input logic [31:0] dat, output logic [46:0] exp);
    logic        err;
    logic [31:0] rd;
    err = !(op == 3'b000 || op == 3'b100) || prm != 3'b000 || sz != 3'b101;
    rd  = 32'h0;
    if (!err && op == 3'b100) rd = mdl[k][addr];
    if (!err && op == 3'b000) mdl[k][addr] = dat;
    exp = {(op == 3'b100) ? 3'b001 : 3'b000, 2'b00, 2'b00, sz, src, err, rd, 1'b1, 1'b0};
  endtask

  task automatic send(input int k, input logic [2:0] op, input logic [2:0] prm,
                      input logic [2:0] sz, input logic [1:0] src, input logic [9:0] addr,
                      input logic [31:0] dat, output logic [46:0] resp, output int lat);
    a_ch[k] = {op, prm, sz, src, addr, dat, 1'b1, 1'b0};
    @(posedge clk); #1;
    a_ch[k][1] = 1'b0;
    lat = 1;
    while (d_ch[k][1] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (d_ch[k][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL d_valid_timeout dut%0d: d_valid=%b required 1", k, d_ch[k][1]);
    end
    resp = d_ch[k];
    d_rdy[k] = 1'b1;
    @(posedge clk); #1;
    d_rdy[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; a_ch[k] = '0; d_rdy[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (d_ch[k] !== 47'd0 || a_rdy[k] !== 1'b1 || st[k] !== 2'b00) begin
        n_fail++;
        $display("FAIL reset dut%0d: d=%h a_ready=%b state=%b required 0/1/00",
                 k, d_ch[k], a_rdy[k], st[k]);
      end
      rstn[k] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [46:0] exp, resp;
    int lat;
    model(0, 3'b000, 3'b000, 3'b101, 2'd2, 10'h005, 32'hDEADBEEF, exp);
    send(0, 3'b000, 3'b000, 3'b101, 2'd2, 10'h005, 32'hDEADBEEF, resp, lat);
    n_tests++;
    if (resp !== exp || lat !== 1) begin
      n_fail++;
      $display("FAIL store_put: d=%h lat=%0d required %h lat=1", resp, lat, exp);
    end
    model(0, 3'b100, 3'b000, 3'b101, 2'd1, 10'h005, 32'h0, exp);
    send(0, 3'b100, 3'b000, 3'b101, 2'd1, 10'h005, 32'h0, resp, lat);
    n_tests++;
    if (resp !== exp || resp[33:2] !== 32'hDEADBEEF || resp[41:37] !== 5'b00101) begin
      n_fail++;
      $display("FAIL load_get: d=%h required %h", resp, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [46:0] exp, snap;
    model(0, 3'b100, 3'b000, 3'b101, 2'd3, 10'h005, 32'h0, exp);
    a_ch[0] = {3'b100, 3'b000, 3'b101, 2'd3, 10'h005, 32'h0, 1'b1, 1'b0};
    @(posedge clk); #1;
    // Competing Put held while busy must be ignored.
    a_ch[0] = {3'b000, 3'b000, 3'b101, 2'd0, 10'h005, 32'h12345678, 1'b1, 1'b0};
    snap = d_ch[0];
    n_tests++;
    if (snap !== exp) begin
      n_fail++;
      $display("FAIL bp_first: d=%h required %h", snap, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (d_ch[0] !== exp || a_rdy[0] !== 1'b0 || st[0] !== 2'b10) begin
        n_fail++;
        $display("FAIL bp_hold%0d: d=%h a_ready=%b state=%b required %h/0/10",
                 i, d_ch[0], a_rdy[0], st[0], exp);
      end
    end
    a_ch[0][1] = 1'b0;
    d_rdy[0] = 1'b1;
    @(posedge clk); #1;
    d_rdy[0] = 1'b0;
    n_tests++;
    if (d_ch[0][1] !== 1'b0 || a_rdy[0] !== 1'b1 || st[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_release: d_valid=%b a_ready=%b state=%b required 0/1/00",
               d_ch[0][1], a_rdy[0], st[0]);
    end
  endtask

  task automatic test_errors();
    logic [46:0] exp, resp;
    logic [31:0] dat;
    int lat;
    dat = $urandom;
    model(0, 3'b010, 3'b000, 3'b101, 2'd1, 10'h005, dat, exp);
    send(0, 3'b010, 3'b000, 3'b101, 2'd1, 10'h005, dat, resp, lat);
    n_tests++;
    if (resp !== exp || resp[34] !== 1'b1 || resp[46:44] !== 3'b000) begin
      n_fail++;
      $display("FAIL err_opcode: d=%h required %h", resp, exp);
    end
    model(0, 3'b100, 3'b000, 3'b101, 2'd0, 10'h005, 32'h0, exp);
    send(0, 3'b100, 3'b000, 3'b101, 2'd0, 10'h005, 32'h0, resp, lat);
    n_tests++;
    if (resp !== exp) begin
      n_fail++;
      $display("FAIL err_opcode_mem: d=%h required %h", resp, exp);
    end
    dat = $urandom;
    model(0, 3'b000, 3'b000, 3'b101, 2'd0, 10'h3FF, dat, exp);
    send(0, 3'b000, 3'b000, 3'b101, 2'd0, 10'h3FF, dat, resp, lat);
    dat = ~dat;
    model(0, 3'b000, 3'b000, 3'b010, 2'd3, 10'h3FF, dat, exp);
    send(0, 3'b000, 3'b000, 3'b010, 2'd3, 10'h3FF, dat, resp, lat);
    n_tests++;
    if (resp !== exp || resp[34] !== 1'b1) begin
      n_fail++;
      $display("FAIL err_size: d=%h required %h", resp, exp);
    end
    model(0, 3'b100, 3'b000, 3'b101, 2'd2, 10'h3FF, 32'h0, exp);
    send(0, 3'b100, 3'b000, 3'b101, 2'd2, 10'h3FF, 32'h0, resp, lat);
    n_tests++;
    if (resp !== exp) begin
      n_fail++;
      $display("FAIL err_size_mem: d=%h required %h", resp, exp);
    end
    model(0, 3'b100, 3'b001, 3'b101, 2'd1, 10'h3FF, 32'h0, exp);
    send(0, 3'b100, 3'b001, 3'b101, 2'd1, 10'h3FF, 32'h0, resp, lat);
    n_tests++;
    if (resp !== exp || resp[46:44] !== 3'b001 || resp[33:2] !== 32'h0) begin
      n_fail++;
      $display("FAIL err_param_get: d=%h required %h", resp, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [46:0] exp;
    logic [2:0]  op;
    logic [1:0]  src;
    logic [9:0]  addr;
    logic [31:0] dat;
    d_rdy[0] = 1'b1;
    for (int j = 0; j < 2048; j++) begin
      addr = 10'(j >> 1);
      op   = j[0] ? 3'b100 : 3'b000;
      src  = 2'($urandom);
      dat  = $urandom;
      model(0, op, 3'b000, 3'b101, src, addr, dat, exp);
      a_ch[0] = {op, 3'b000, 3'b101, src, addr, dat, 1'b1, 1'b0};
      @(posedge clk); #1;
      a_ch[0][1] = 1'b0;
      n_tests++;
      if (d_ch[0] !== exp) begin
        n_fail++;
        $display("FAIL b2b j=%0d: d=%h required %h", j, d_ch[0], exp);
      end
      @(posedge clk); #1;
    end
    d_rdy[0] = 1'b0;
    n_tests++;
    if (d_ch[0][1] !== 1'b0 || a_rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_end: d_valid=%b a_ready=%b required 0/1", d_ch[0][1], a_rdy[0]);
    end
  endtask

  task automatic test_random();
    logic [46:0] exp, resp;
    logic [2:0]  op, prm, sz;
    int lat;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 3'b000;
        1, 3:    op = 3'b100;
        default: op = 3'($urandom);
      endcase
      prm = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      sz  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b101;
      model(0, op, prm, sz, 2'(i), 10'(i * 37), 32'(i * 32'h01010101 + 7), exp);
      send(0, op, prm, sz, 2'(i), 10'(i * 37), 32'(i * 32'h01010101 + 7), resp, lat);
      n_tests++;
      if (resp !== exp || lat !== 1) begin
        n_fail++;
        $display("FAIL random%0d: d=%h lat=%0d required %h lat=1", i, resp, lat, exp);
      end
    end
  endtask

  task automatic test_latency();
    logic [46:0] exp, resp;
    logic [31:0] dat;
    logic [1:0]  exp_st;
    logic        exp_dv;
    int lat;
    dat = $urandom;
    model(1, 3'b000, 3'b000, 3'b101, 2'd1, 10'h020, dat, exp);
    send(1, 3'b000, 3'b000, 3'b101, 2'd1, 10'h020, dat, resp, lat);
    n_tests++;
    if (resp !== exp || lat !== 4) begin
      n_fail++;
      $display("FAIL lat3_put: d=%h lat=%0d required %h lat=4", resp, lat, exp);
    end
    model(1, 3'b100, 3'b000, 3'b101, 2'd2, 10'h020, 32'h0, exp);
    a_ch[1] = {3'b100, 3'b000, 3'b101, 2'd2, 10'h020, 32'h0, 1'b1, 1'b0};
    @(posedge clk); #1;
    a_ch[1][1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_st = (i == 3) ? 2'b10 : 2'b01;
      exp_dv = (i == 3);
      n_tests++;
      if (st[1] !== exp_st || d_ch[1][1] !== exp_dv) begin
        n_fail++;
        $display("FAIL lat3_seq%0d: state=%b d_valid=%b required %b/%b",
                 i, st[1], d_ch[1][1], exp_st, exp_dv);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    n_tests++;
    if (d_ch[1] !== exp) begin
      n_fail++;
      $display("FAIL lat3_get: d=%h required %h", d_ch[1], exp);
    end
    d_rdy[1] = 1'b1;
    @(posedge clk); #1;
    d_rdy[1] = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [46:0] exp, resp;
    logic [31:0] dat;
    int lat;
    dat = $urandom;
    model(1, 3'b000, 3'b000, 3'b101, 2'd0, 10'h010, dat, exp);
    send(1, 3'b000, 3'b000, 3'b101, 2'd0, 10'h010, dat, resp, lat);
    a_ch[1] = {3'b000, 3'b000, 3'b101, 2'd3, 10'h010, ~dat, 1'b1, 1'b0};
    @(posedge clk); #1;
    a_ch[1][1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    #1;
    n_tests++;
    if (d_ch[1] !== 47'd0 || a_rdy[1] !== 1'b1 || st[1] !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_wait: d=%h a_ready=%b state=%b required 0/1/00",
               d_ch[1], a_rdy[1], st[1]);
    end
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    @(posedge clk); #1;
    model(1, 3'b100, 3'b000, 3'b101, 2'd1, 10'h010, 32'h0, exp);
    send(1, 3'b100, 3'b000, 3'b101, 2'd1, 10'h010, 32'h0, resp, lat);
    n_tests++;
    if (resp !== exp || resp[33:2] !== dat) begin
      n_fail++;
      $display("FAIL rst_mid_wait_mem: d=%h required %h", resp, exp);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_random();
    test_latency();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
